// File: rtl/reg_file_sb_if.sv
// Bus bundle between the decode stage and the register file with busy
// scoreboard: read ports, Bus D writeback, reserve channel and hazard status.
`timescale 1ns/1ps
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] AA;
  logic [ADDR_W-1:0] BA;
  logic              A_rd;
  logic              B_rd;
  logic [DATA_W-1:0] A_data;
  logic [DATA_W-1:0] B_data;
  logic [ADDR_W-1:0] DA;
  logic [DATA_W-1:0] D_data;
  logic              RW;
  logic              RSV;
  logic [ADDR_W-1:0] DA_rsv;
  logic              stall;
  logic [ADDR_W:0]   pend_cnt;
  logic              rsv_err;

  // Decode/writeback side: drives addresses, write and reserve requests.
  modport master (
    output AA, BA, A_rd, B_rd, DA, D_data, RW, RSV, DA_rsv,
    input  A_data, B_data, stall, pend_cnt, rsv_err
  );

  // Register file side.
  modport slave (
    input  AA, BA, A_rd, B_rd, DA, D_data, RW, RSV, DA_rsv,
    output A_data, B_data, stall, pend_cnt, rsv_err
  );
endinterface

// File: rtl/reg_file_sb.sv
// General register file feeding Bus A and the B-bus mux. Combinational reads
// with write-to-read bypass, plus a per-register busy scoreboard that flags
// reads of registers whose multi-cycle writeback is still outstanding.
`timescale 1ns/1ps
module reg_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [ADDR_W:0]   pend_cnt_q;
  logic [ADDR_W:0]   pend_cnt_d;
  logic              rsv_err_q;
  logic              rsv_err_d;
  logic              byp_a_s;
  logic              byp_b_s;
  logic              hit_a_s;
  logic              hit_b_s;

  // Number of set bits; keeps pend_cnt tied to the busy vector by construction.
  function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Bypass, hazard detection and read data selection.
  always_comb begin
    byp_a_s    = bus.RW && (bus.DA == bus.AA);
    byp_b_s    = bus.RW && (bus.DA == bus.BA);
    hit_a_s    = bus.A_rd && busy_q[bus.AA] && !byp_a_s;
    hit_b_s    = bus.B_rd && busy_q[bus.BA] && !byp_b_s;
    bus.A_data = byp_a_s ? bus.D_data : regs_q[bus.AA];
    bus.B_data = byp_b_s ? bus.D_data : regs_q[bus.BA];
    bus.stall  = hit_a_s || hit_b_s;
  end

  // Scoreboard next state: a write clears, a reserve sets, and the reserve wins
  // on a same-address collision because a newer load is then outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      busy_d[i] = (busy_q[i] && !(bus.RW && (bus.DA == ADDR_W'(i))))
                  || (bus.RSV && (bus.DA_rsv == ADDR_W'(i)));
    end
    pend_cnt_d = popcount(busy_d);
    rsv_err_d  = rsv_err_q
                 || (bus.RSV && busy_q[bus.DA_rsv]
                     && !(bus.RW && (bus.DA == bus.DA_rsv)));
  end

  // Register storage: written from the Bus D writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.RW) begin
      regs_q[bus.DA] <= bus.D_data;
    end
  end

  // Scoreboard state, pending count and sticky reserve-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
      rsv_err_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      rsv_err_q  <= rsv_err_d;
    end
  end

  assign bus.pend_cnt = pend_cnt_q;
  assign bus.rsv_err  = rsv_err_q;
endmodule
